// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/update controller that computes and loads the next PC,
// with a small hardware return-address stack for CALL/RET.
module pc_sequencer #(
    parameter int unsigned          ADDR_W       = 12,
    parameter int unsigned          STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              op_valid,
    input  logic [2:0]        op_kind,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc_d,
    output logic              pc_en,
    output logic              busy,
    output logic              halted,
    output logic              stack_err
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_UPDATE = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_d_q, pc_d_d;
    logic                halt_pend_q, halt_pend_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic                push, pop;
    logic                full, empty;
    logic [ADDR_W-1:0]   pc_inc;
    logic [PTR_W-1:0]    push_idx, pop_idx;
    logic                imem_req_q, pc_en_q, busy_q, halted_q;

    assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign push_idx = cnt_q[PTR_W-1:0];
    assign pop_idx  = PTR_W'(cnt_q - CNT_W'(1));

    // Next-state, next-PC and stack-control decode.
    always_comb begin
        state_d     = state_q;
        pc_d_d      = pc_d_q;
        halt_pend_d = halt_pend_q;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d_d      = RESET_VECTOR;
                    halt_pend_d = 1'b0;
                    state_d     = S_UPDATE;
                end
            end
            S_FETCH: begin
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op_valid) begin
                    halt_pend_d = halt_req;
                    state_d     = S_UPDATE;
                    case (op_kind)
                        OP_JUMP:   pc_d_d = target;
                        OP_BRANCH: pc_d_d = cond ? target : pc_inc;
                        OP_CALL: begin
                            if (full) begin
                                err_d   = 1'b1;
                                state_d = S_HALTED;
                            end else begin
                                push   = 1'b1;
                                pc_d_d = target;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                err_d   = 1'b1;
                                state_d = S_HALTED;
                            end else begin
                                pop    = 1'b1;
                                pc_d_d = stack_q[pop_idx];
                            end
                        end
                        OP_HALT: state_d = S_HALTED;
                        default: pc_d_d = pc_inc;
                    endcase
                end
            end
            S_UPDATE: begin
                state_d = halt_pend_q ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, next-PC and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_d_q      <= '0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            imem_req_q  <= 1'b0;
            pc_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_d_q      <= pc_d_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            imem_req_q  <= (state_d == S_FETCH);
            pc_en_q     <= (state_d == S_UPDATE);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_HALTED);
            halted_q    <= (state_d == S_HALTED);
        end
    end

    // Return-address stack: LIFO storage plus occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
        end else begin
            if (push) begin
                stack_q[push_idx] <= pc_inc;
                cnt_q             <= cnt_q + CNT_W'(1);
            end else if (pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign pc_d      = pc_d_q;
    assign pc_en     = pc_en_q;
    assign imem_req  = imem_req_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected PC loads into a queue,
// a negedge monitor pops and compares on every pc_en pulse.
module tb_pc_sequencer;

    localparam logic [2:0] K_NEXT = 3'd0, K_JUMP = 3'd1, K_BRANCH = 3'd2,
                           K_CALL = 3'd3, K_RET = 3'd4, K_HALT = 3'd5;

    logic        clk, reset, start, halt_req, imem_req, imem_ack, op_valid, cond;
    logic [2:0]  op_kind;
    logic [11:0] pc_q, target, pc_d;
    logic        pc_en, busy, halted, stack_err;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q [$];

    pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(4), .RESET_VECTOR(12'h000)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc_q(pc_q),
        .imem_req(imem_req), .imem_ack(imem_ack), .op_valid(op_valid), .op_kind(op_kind),
        .cond(cond), .target(target), .pc_d(pc_d), .pc_en(pc_en), .busy(busy),
        .halted(halted), .stack_err(stack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The program counter register the sequencer drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      pc_q <= '0;
        else if (pc_en) pc_q <= pc_d;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every PC load must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && pc_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pc_en", 1, 0);
            end else begin
                chk("pc_d", int'(pc_d), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) chk("imem_req_timeout", 0, 1);
    endtask

    task automatic start_from_idle();
        exp_q.push_back(12'h000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_pc_en", int'(pc_en), 1);
        chk("start_busy", int'(busy), 1);
        @(negedge clk);
        chk("start_imem_req", int'(imem_req), 1);
        chk("start_pc_en_off", int'(pc_en), 0);
    endtask

    task automatic resume(input logic [11:0] hold_pc);
        chk("resume_halted", int'(halted), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("resume_imem_req", int'(imem_req), 1);
        chk("resume_halted_off", int'(halted), 0);
        chk("resume_pc_hold", int'(pc_q), int'(hold_pc));
    endtask

    // One instruction: fetch handshake, decode, then expected update / halt.
    task automatic instr(input logic [2:0] kind, input logic c, input logic [11:0] tgt,
                         input logic hr, input int ack_dly, input int ov_dly,
                         input logic upd, input logic [11:0] exp_pc, input logic end_halt);
        wait_req();
        for (int i = 0; i < ack_dly; i++) begin
            chk("fetch_stall_req", int'(imem_req), 1);
            @(negedge clk);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("decode_req_off", int'(imem_req), 0);
        for (int i = 0; i < ov_dly; i++) begin
            chk("decode_stall_pc_en", int'(pc_en), 0);
            @(negedge clk);
        end
        op_kind  = kind;
        cond     = c;
        target   = tgt;
        halt_req = hr;
        op_valid = 1'b1;
        if (upd) exp_q.push_back(exp_pc);
        @(negedge clk);
        op_valid = 1'b0;
        halt_req = 1'b0;
        chk("pc_en", int'(pc_en), int'(upd));
        if (upd) begin
            @(negedge clk);
            chk("after_update_pc_en", int'(pc_en), 0);
            if (end_halt) chk("after_update_halted", int'(halted), 1);
            else          chk("after_update_req", int'(imem_req), 1);
        end else begin
            chk("no_update_halted", int'(halted), 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_stack_err", int'(stack_err), 0);
        chk("rst_pc_d", int'(pc_d), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
        op_valid = 1'b0; op_kind = 3'd0; cond = 1'b0; target = '0;
        #1;
        chk("por_pc_en", int'(pc_en), 0);
        do_reset();

        // Start, sequential with wrap, branches and jump.
        start_from_idle();
        instr(K_JUMP, 0, 12'hFFE, 0, 0, 0, 1, 12'hFFE, 0);
        instr(K_NEXT, 0, 12'h000, 0, 0, 0, 1, 12'hFFF, 0);
        instr(K_NEXT, 0, 12'h000, 0, 0, 0, 1, 12'h000, 0);
        instr(K_JUMP, 0, 12'h010, 0, 0, 0, 1, 12'h010, 0);
        instr(K_BRANCH, 0, 12'h200, 0, 0, 0, 1, 12'h011, 0);
        instr(K_BRANCH, 1, 12'h200, 0, 0, 0, 1, 12'h200, 0);
        instr(K_JUMP, 0, 12'h3A5, 0, 0, 0, 1, 12'h3A5, 0);
        instr(3'd7, 1, 12'h777, 0, 0, 0, 1, 12'h3A6, 0);

        // Nested calls, overflow, then returns in LIFO order.
        instr(K_JUMP, 0, 12'h001, 0, 0, 0, 1, 12'h001, 0);
        instr(K_CALL, 0, 12'h101, 0, 0, 0, 1, 12'h101, 0);
        instr(K_CALL, 0, 12'h201, 0, 0, 0, 1, 12'h201, 0);
        instr(K_CALL, 0, 12'h301, 0, 0, 0, 1, 12'h301, 0);
        instr(K_CALL, 0, 12'h050, 0, 0, 0, 1, 12'h050, 0);
        instr(K_CALL, 0, 12'h123, 0, 0, 0, 0, 12'h000, 1);
        chk("overflow_err", int'(stack_err), 1);
        resume(12'h050);
        instr(K_RET, 0, 12'h000, 0, 0, 0, 1, 12'h302, 0);
        instr(K_RET, 0, 12'h000, 0, 0, 0, 1, 12'h202, 0);
        instr(K_RET, 0, 12'h000, 0, 0, 0, 1, 12'h102, 0);
        instr(K_RET, 0, 12'h000, 0, 0, 0, 1, 12'h002, 0);
        chk("err_sticky", int'(stack_err), 1);

        // Underflow on an empty stack.
        do_reset();
        start_from_idle();
        instr(K_RET, 0, 12'h000, 0, 0, 0, 0, 12'h000, 1);
        chk("underflow_err", int'(stack_err), 1);
        chk("underflow_pc", int'(pc_q), 0);

        // halt_req during NEXT: PC still updates, then halt; resume keeps PC.
        do_reset();
        start_from_idle();
        instr(K_NEXT, 0, 12'h000, 1, 0, 0, 1, 12'h001, 1);
        chk("halt_no_err", int'(stack_err), 0);
        resume(12'h001);
        instr(K_NEXT, 0, 12'h000, 0, 5, 3, 1, 12'h002, 0);
        instr(K_HALT, 0, 12'h000, 0, 0, 0, 0, 12'h000, 1);
        chk("halt_op_pc", int'(pc_q), 12'h002);

        // Asynchronous reset in the middle of DECODE.
        resume(12'h002);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req", int'(imem_req), 0);
        chk("mid_rst_halted", int'(halted), 0);
        chk("mid_rst_pc_d", int'(pc_d), 0);
        @(negedge clk);
        reset = 1'b0;
        op_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("mid_rst_idle", int'(busy), 0);
        chk("mid_rst_no_en", int'(pc_en), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
